mem_data_mp: RTL



---
 rtl/mem_pkg.sv | 13 +
 rtl/mem_clr_fsm.sv | 68 ++++++
 rtl/mem_data_mp.sv | 105 ++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and limits for the multi-read-port data memory.
package mem_pkg;

  // Clear engine states
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  // Upper bound on the number of read ports
  localparam int unsigned MAX_NRDPT = 4;

endpackage

// File: rtl/mem_clr_fsm.sv
// Zero-fill engine: walks every address once per clear request and owns
// the busy / clr_done status.
module mem_clr_fsm
  import mem_pkg::*;
#(
  parameter int unsigned NADDRE = 64,
  parameter int unsigned AW     = (NADDRE > 1) ? $clog2(NADDRE) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  output logic          busy,
  output logic          clr_done,
  output logic          clr_we_c,
  output logic [AW-1:0] clr_addr_c
);

  localparam logic [AW-1:0] LAST = AW'(NADDRE - 1);

  clr_state_e    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  // State register; busy and clr_done are registered copies of the next state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      busy     <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy     <= (state_d == ST_CLEAR);
      clr_done <= (state_d == ST_CLEAR) && (cnt_d == LAST);
    end
  end

  // Next state; clr is only honoured from idle so a running clear never restarts
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clr_we_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clr) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        clr_we_c = 1'b1;
        if (cnt_q == LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign clr_addr_c = cnt_q;

endmodule

// File: rtl/mem_data_mp.sv
// Multi-read-port data memory with a hardware clear engine.
// Build option: MEM_BYPASS_EN selects write-first reads on same-address
// collisions (including clear writes); undefined gives read-first reads.
// Array contents are not reset and power up undefined.
module mem_data_mp
  import mem_pkg::*;
#(
  parameter int unsigned NADDRE = 64,
  parameter int unsigned NBDATA = 32,
  parameter int unsigned NRDPT  = 2,
  parameter int unsigned AW     = (NADDRE > 1) ? $clog2(NADDRE) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr,
  input  logic [AW-1:0]                  addr_wr,
  input  logic signed [NBDATA-1:0]       data_in,
  input  logic [NRDPT*AW-1:0]            addr_rd,
  output logic signed [NRDPT*NBDATA-1:0] data_out,
  input  logic                           clr,
  output logic                           busy,
  output logic                           clr_done,
  output logic                           wr_drop
);

  logic [NBDATA-1:0] mem [NADDRE];

  logic              clr_we_c;
  logic [AW-1:0]     clr_addr_c;
  logic              we_c;
  logic [AW-1:0]     wa_c;
  logic [NBDATA-1:0] wd_c;

  mem_clr_fsm #(
    .NADDRE (NADDRE),
    .AW     (AW)
  ) u_clr_fsm (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .busy       (busy),
    .clr_done   (clr_done),
    .clr_we_c   (clr_we_c),
    .clr_addr_c (clr_addr_c)
  );

  // External writes are dropped while the clear engine owns the write port
  assign wr_drop = wr & busy;

  // Write port mux: clear writes win, external writes must be in range
  always_comb begin
    we_c = 1'b0;
    wa_c = addr_wr;
    wd_c = data_in;
    if (clr_we_c) begin
      we_c = 1'b1;
      wa_c = clr_addr_c;
      wd_c = '0;
    end else if (wr && (32'(addr_wr) < NADDRE)) begin
      we_c = 1'b1;
    end
  end

  // Array write; contents deliberately untouched by reset
  always_ff @(posedge clk) begin
    if (we_c) begin
      mem[wa_c] <= wd_c;
    end
  end

  for (genvar k = 0; k < int'(MAX_NRDPT); k++) begin : g_rd
    if (k < int'(NRDPT)) begin : g_port
      logic [AW-1:0]     ra;
      logic [NBDATA-1:0] rd_c;
      logic [NBDATA-1:0] rd_q;

      assign ra = addr_rd[k*AW +: AW];

      // Read mux: out-of-range reads as zero, optional same-cycle bypass
      always_comb begin
        rd_c = '0;
        if (32'(ra) < NADDRE) begin
          rd_c = mem[ra];
        end
`ifdef MEM_BYPASS_EN
        if (we_c && (wa_c == ra)) begin
          rd_c = wd_c;
        end
`endif
      end

      // Registered read data, never stalled
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          rd_q <= '0;
        end else begin
          rd_q <= rd_c;
        end
      end

      assign data_out[k*NBDATA +: NBDATA] = rd_q;
    end
  end

endmodule
